// File: rtl/bfm_format_conv_arbiter_if.sv
// Port bundle for bfm_format_conv_arbiter: requester side, converter side,
// output stream, flush handshake and status.
`ifndef MATCH_TABLE_WIDTH
`define MATCH_TABLE_WIDTH 32
`endif

interface bfm_format_conv_arbiter_if #(
    parameter int C_NUM_REQ    = 4,
    parameter int C_DATA_WIDTH = `MATCH_TABLE_WIDTH,
    parameter int C_ID_WIDTH   = $clog2(C_NUM_REQ)
);
    logic [C_NUM_REQ-1:0]              s_req_valid;
    logic [C_NUM_REQ*C_DATA_WIDTH-1:0] s_req_data;
    logic [C_NUM_REQ-1:0]              s_req_ready;
    logic                              conv_tvalid;
    logic [C_DATA_WIDTH-1:0]           conv_tdata;
    logic                              conv_result_tvalid;
    logic [C_DATA_WIDTH-1:0]           conv_result_tdata;
    logic                              m_axis_tvalid;
    logic [C_DATA_WIDTH-1:0]           m_axis_tdata;
    logic [C_ID_WIDTH-1:0]             m_axis_tid;
    logic                              m_axis_tready;
    logic                              flush_req;
    logic                              flush_done;
    logic                              err_orphan;
    logic [C_NUM_REQ*32-1:0]           stat_grant_cnt;

    modport slave (
        input  s_req_valid, s_req_data, conv_result_tvalid, conv_result_tdata,
               m_axis_tready, flush_req,
        output s_req_ready, conv_tvalid, conv_tdata, m_axis_tvalid, m_axis_tdata,
               m_axis_tid, flush_done, err_orphan, stat_grant_cnt
    );

    modport master (
        output s_req_valid, s_req_data, conv_result_tvalid, conv_result_tdata,
               m_axis_tready, flush_req,
        input  s_req_ready, conv_tvalid, conv_tdata, m_axis_tvalid, m_axis_tdata,
               m_axis_tid, flush_done, err_orphan, stat_grant_cnt
    );
endinterface

// File: rtl/bfm_format_conv_arbiter.sv
// Round-robin sharing of one fixed-latency, non-stallable converter among C_NUM_REQ
// requesters, with credit-guarded output FIFO. Optional grant counters: BFM_CONV_ARB_STATS_EN.
`ifndef MATCH_TABLE_WIDTH
`define MATCH_TABLE_WIDTH 32
`endif

module bfm_format_conv_arbiter #(
    parameter int C_NUM_REQ      = 4,
    parameter int C_DATA_WIDTH   = `MATCH_TABLE_WIDTH,
    parameter int C_CONV_LATENCY = 6,
    parameter int C_FIFO_DEPTH   = 16,
    parameter int C_ID_WIDTH     = $clog2(C_NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    bfm_format_conv_arbiter_if.slave bus
);
    localparam int TAG_DEPTH = C_CONV_LATENCY + 2;
    localparam int TAG_AW    = $clog2(TAG_DEPTH);
    localparam int FIFO_AW   = $clog2(C_FIFO_DEPTH);
    localparam int OCC_W     = $clog2(C_FIFO_DEPTH + TAG_DEPTH + 1);
    localparam int Q_W       = $clog2(C_CONV_LATENCY + 1);

    typedef enum logic [1:0] {ST_QUIESCE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    typedef struct packed {
        logic [C_ID_WIDTH-1:0]   id;
        logic [C_DATA_WIDTH-1:0] data;
    } entry_t;

    state_t                  state, state_next;
    logic [Q_W-1:0]          q_cnt;

    logic [C_ID_WIDTH-1:0]   rr_ptr, grant_idx;
    logic [C_NUM_REQ-1:0]    grant;
    logic                    grant_any, grant_en;

    logic                    conv_valid_q;
    logic [C_DATA_WIDTH-1:0] conv_data_q;

    logic [C_ID_WIDTH-1:0]   tag_mem [TAG_DEPTH];
    logic [TAG_AW-1:0]       tag_wr, tag_rd;
    logic [TAG_AW:0]         inflight;

    entry_t                  out_mem [C_FIFO_DEPTH];
    logic [FIFO_AW-1:0]      out_wr, out_rd;
    logic [FIFO_AW:0]        out_count;
    logic                    out_valid, out_pop;

    logic                    result_live, result_accept, result_orphan, err_q;
    logic [OCC_W-1:0]        occupancy;

    function automatic logic [C_ID_WIDTH-1:0] rr_wrap(input int base, input int off);
        int s;
        s = base + off;
        if (s >= C_NUM_REQ) s = s - C_NUM_REQ;
        return C_ID_WIDTH'(s);
    endfunction

    function automatic logic [TAG_AW-1:0] tag_next(input logic [TAG_AW-1:0] p);
        return (p == TAG_AW'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Every in-flight entry owns a reserved output-FIFO slot, since the converter cannot stall.
    assign occupancy = OCC_W'(inflight) + OCC_W'(out_count);
    assign grant_en  = (state == ST_RUN) && !rst && !bus.flush_req &&
                       (occupancy < OCC_W'(C_FIFO_DEPTH));

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < C_NUM_REQ; k++) begin
            if (grant_en && !grant_any && bus.s_req_valid[rr_wrap(int'(rr_ptr), k)]) begin
                grant_idx        = rr_wrap(int'(rr_ptr), k);
                grant[grant_idx] = 1'b1;
                grant_any        = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous, active-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            conv_valid_q <= 1'b0;
            conv_data_q  <= '0;
        end else begin
            conv_valid_q <= grant_any;
            if (grant_any) begin
                rr_ptr      <= rr_wrap(int'(grant_idx), 1);
                conv_data_q <= bus.s_req_data[int'(grant_idx)*C_DATA_WIDTH +: C_DATA_WIDTH];
            end
        end
    end

    // Results seen while quiescing belong to work issued before reset.
    assign result_live   = bus.conv_result_tvalid && (state != ST_QUIESCE);
    assign result_accept = result_live && (inflight != '0);
    assign result_orphan = result_live && (inflight == '0);

    // NOTE: storage arrays are not reset; pointers and counts alone define what is valid.
    always_ff @(posedge clk) begin
        if (grant_any) tag_mem[tag_wr] <= grant_idx;
        if (result_accept) out_mem[out_wr] <= '{id: tag_mem[tag_rd], data: bus.conv_result_tdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wr   <= '0;
            tag_rd   <= '0;
            inflight <= '0;
        end else begin
            if (grant_any)     tag_wr <= tag_next(tag_wr);
            if (result_accept) tag_rd <= tag_next(tag_rd);
            case ({grant_any, result_accept})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase
        end
    end

    assign out_valid = (out_count != '0);
    assign out_pop   = out_valid && bus.m_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_wr    <= '0;
            out_rd    <= '0;
            out_count <= '0;
        end else begin
            if (result_accept) out_wr <= out_wr + 1'b1;
            if (out_pop)       out_rd <= out_rd + 1'b1;
            case ({result_accept, out_pop})
                2'b10:   out_count <= out_count + 1'b1;
                2'b01:   out_count <= out_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                err_q <= 1'b0;
        else if (result_orphan) err_q <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_QUIESCE;
            q_cnt <= '0;
        end else begin
            state <= state_next;
            q_cnt <= (state == ST_QUIESCE) ? q_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_QUIESCE: if (q_cnt == Q_W'(C_CONV_LATENCY - 1)) state_next = ST_RUN;
            ST_RUN:     if (bus.flush_req) state_next = ST_DRAIN;
            ST_DRAIN:   if (occupancy == '0) state_next = ST_DONE;
            ST_DONE:    state_next = ST_RUN;
            default:    state_next = ST_QUIESCE;
        endcase
    end

`ifdef BFM_CONV_ARB_STATS_EN
    logic [31:0] grant_cnt [C_NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_NUM_REQ; i++) grant_cnt[i] <= '0;
        end else if (grant_any) begin
            grant_cnt[grant_idx] <= grant_cnt[grant_idx] + 32'd1;
        end
    end

    for (genvar i = 0; i < C_NUM_REQ; i++) begin : g_stat
        assign bus.stat_grant_cnt[i*32 +: 32] = grant_cnt[i];
    end
`else
    assign bus.stat_grant_cnt = '0;
`endif

    assign bus.s_req_ready   = grant;
    assign bus.conv_tvalid   = conv_valid_q;
    assign bus.conv_tdata    = conv_data_q;
    assign bus.m_axis_tvalid = out_valid;
    assign bus.m_axis_tdata  = out_valid ? out_mem[out_rd].data : '0;
    assign bus.m_axis_tid    = out_valid ? out_mem[out_rd].id : '0;
    assign bus.flush_done    = (state == ST_DONE);
    assign bus.err_orphan    = err_q;
endmodule
